// File: rtl/mult_seq_pkg.sv
// mult_seq_pkg: register map, status bits, response code and sequencer states for mult_seq_ctrl
package mult_seq_pkg;
  localparam logic [3:0] OFF_A     = 4'h0;
  localparam logic [3:0] OFF_B     = 4'h4;
  localparam logic [3:0] OFF_RES   = 4'h8;
  localparam logic [3:0] OFF_CSR   = 4'hC;
  localparam int         START_BIT = 0;
  localparam int         DONE_BIT  = 1;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  typedef enum logic [2:0] {IDLE, WR_A, WR_B, WR_GO, POLL, RD_RES, DONE} seq_state_t;
endpackage

// File: rtl/mult_seq_ctrl_xact.sv
// mult_axil_xact: single-outstanding AXI4-Lite master engine, one read or write per accepted command
module mult_axil_xact #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_rnw,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          done,
  output logic [DW-1:0] rdata,
  output logic [1:0]    resp,
  output logic [AW-1:0] m_awaddr,
  output logic          m_awvalid,
  input  logic          m_awready,
  output logic [DW-1:0] m_wdata,
  output logic          m_wvalid,
  input  logic          m_wready,
  input  logic [1:0]    m_bresp,
  input  logic          m_bvalid,
  output logic          m_bready,
  output logic [AW-1:0] m_araddr,
  output logic          m_arvalid,
  input  logic          m_arready,
  input  logic [DW-1:0] m_rdata,
  input  logic [1:0]    m_rresp,
  input  logic          m_rvalid,
  output logic          m_rready
);
  assign done      = (m_bvalid & m_bready) | (m_rvalid & m_rready);
  assign cmd_ready = ~(m_bready | m_rready) | done;
  assign rdata     = m_rdata;
  assign resp      = m_bready ? m_bresp : m_rresp;
  // a command accepted in the completion cycle launches back-to-back with no idle gap
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      m_awvalid <= 1'b0;
      m_wvalid  <= 1'b0;
      m_bready  <= 1'b0;
      m_arvalid <= 1'b0;
      m_rready  <= 1'b0;
      m_awaddr  <= '0;
      m_wdata   <= '0;
      m_araddr  <= '0;
    end else begin
      if (m_awvalid && m_awready) m_awvalid <= 1'b0;
      if (m_wvalid && m_wready) m_wvalid <= 1'b0;
      if (m_bvalid && m_bready) m_bready <= 1'b0;
      if (m_arvalid && m_arready) m_arvalid <= 1'b0;
      if (m_rvalid && m_rready) m_rready <= 1'b0;
      if (cmd_valid && cmd_ready) begin
        if (cmd_rnw) begin
          m_arvalid <= 1'b1;
          m_rready  <= 1'b1;
          m_araddr  <= cmd_addr;
        end else begin
          m_awvalid <= 1'b1;
          m_wvalid  <= 1'b1;
          m_bready  <= 1'b1;
          m_awaddr  <= cmd_addr;
          m_wdata   <= cmd_wdata;
        end
      end
    end
endmodule

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: job sequencer driving the multiplier slave over AXI4-Lite (write A, B, start; poll; read product)
// MULT_SEQ_TIMEOUT_EN adds a poll counter that aborts with res_err after POLL_LIMIT status reads.
module mult_seq_ctrl
  import mult_seq_pkg::*;
#(
  parameter int                            C_M_AXI_ADDR_WIDTH = 32,
  parameter int                            C_M_AXI_DATA_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR          = '0,
  parameter int                            POLL_LIMIT         = 255
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic                            job_valid,
  output logic                            job_ready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   job_a,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   job_b,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   res_data,
  output logic                            res_err,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  seq_state_t state, state_n;
  logic [DW-1:0] op_b, cmd_wdata, xrdata;
  logic [3:0] cmd_off;
  logic [1:0] xresp;
  logic cmd_valid, cmd_ready, cmd_rnw, xdone, xerr, take, timeout, set_res, set_err;
  assign M_AXI_AWPROT = '0;
  assign M_AXI_ARPROT = '0;
  assign M_AXI_WSTRB  = '1;
  assign xerr = xresp != RESP_OKAY;
  assign take = job_valid & job_ready & cmd_ready;
`ifdef MULT_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(POLL_LIMIT + 1) > 8 ? $clog2(POLL_LIMIT + 1) : 8;
  logic [CW-1:0] poll_cnt;
  assign timeout = poll_cnt == CW'(POLL_LIMIT - 1);
  // held at zero outside POLL, so every entry into POLL starts a fresh count
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) poll_cnt <= '0;
    else if (state != POLL) poll_cnt <= '0;
    else if (xdone) poll_cnt <= poll_cnt + 1'b1;
`else
  assign timeout = 1'b0;
`endif
  // each step issues the next command in the cycle the previous one completes
  always_comb begin
    state_n   = state;
    cmd_valid = 1'b0;
    cmd_rnw   = 1'b0;
    cmd_off   = OFF_A;
    cmd_wdata = job_a;
    set_res   = 1'b0;
    set_err   = 1'b0;
    if (xdone && xerr) begin
      state_n = DONE;
      set_res = 1'b1;
      set_err = 1'b1;
    end else begin
      case (state)
        IDLE: if (take) begin
          cmd_valid = 1'b1;
          state_n   = WR_A;
        end
        WR_A: if (xdone) begin
          cmd_valid = 1'b1;
          cmd_off   = OFF_B;
          cmd_wdata = op_b;
          state_n   = WR_B;
        end
        WR_B: if (xdone) begin
          cmd_valid = 1'b1;
          cmd_off   = OFF_CSR;
          cmd_wdata = DW'(1) << START_BIT;
          state_n   = WR_GO;
        end
        WR_GO: if (xdone) begin
          cmd_valid = 1'b1;
          cmd_rnw   = 1'b1;
          cmd_off   = OFF_CSR;
          state_n   = POLL;
        end
        POLL: if (xdone) begin
          cmd_valid = xrdata[DONE_BIT] | ~timeout;
          cmd_rnw   = 1'b1;
          cmd_off   = xrdata[DONE_BIT] ? OFF_RES : OFF_CSR;
          state_n   = xrdata[DONE_BIT] ? RD_RES : timeout ? DONE : POLL;
          set_res   = ~xrdata[DONE_BIT] & timeout;
          set_err   = ~xrdata[DONE_BIT] & timeout;
        end
        RD_RES: if (xdone) begin
          state_n = DONE;
          set_res = 1'b1;
        end
        DONE: if (res_ready) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) begin
      state     <= IDLE;
      job_ready <= 1'b1;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_err   <= 1'b0;
      op_b      <= '0;
    end else begin
      state     <= state_n;
      job_ready <= state_n == IDLE;
      res_valid <= state_n == DONE;
      if (state == IDLE && take) op_b <= job_b;
      if (set_res) begin
        res_data <= set_err ? '0 : xrdata;
        res_err  <= set_err;
      end
    end
  mult_axil_xact #(.AW(AW), .DW(DW)) u_xact (
    .clk       (ACLK),
    .rst       (ARESET),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_rnw   (cmd_rnw),
    .cmd_addr  (BASE_ADDR + AW'(cmd_off)),
    .cmd_wdata (cmd_wdata),
    .done      (xdone),
    .rdata     (xrdata),
    .resp      (xresp),
    .m_awaddr  (M_AXI_AWADDR),
    .m_awvalid (M_AXI_AWVALID),
    .m_awready (M_AXI_AWREADY),
    .m_wdata   (M_AXI_WDATA),
    .m_wvalid  (M_AXI_WVALID),
    .m_wready  (M_AXI_WREADY),
    .m_bresp   (M_AXI_BRESP),
    .m_bvalid  (M_AXI_BVALID),
    .m_bready  (M_AXI_BREADY),
    .m_araddr  (M_AXI_ARADDR),
    .m_arvalid (M_AXI_ARVALID),
    .m_arready (M_AXI_ARREADY),
    .m_rdata   (M_AXI_RDATA),
    .m_rresp   (M_AXI_RRESP),
    .m_rvalid  (M_AXI_RVALID),
    .m_rready  (M_AXI_RREADY)
  );
endmodule
